counter_bank: RTL

Parametrised bank of independent up/down counters whose registered values are exposed directly to the parent, generalising the single free-running public-register submodule. Each channel has its own increment, decrement and saturate/wrap mode, a shared load port, one-cycle wrap pulses and sticky overflow flags. It sits below a parent module that reads counts through a flat output bus or a channel-select read port.

---
 rtl/counter_bank.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/counter_bank.sv
// -----------------------------------------------------------------------------
// counter_bank
//
// A bank of CHANNELS independent WIDTH-bit up/down counters. The registers are
// exposed directly to the parent. Each channel has its own increment and
// decrement requests and its own saturate/wrap mode. All channels share one
// load port. Each channel reports one-cycle wrap and saturation pulses and
// keeps a sticky overflow flag.
//
// Parameters:
//   WIDTH        bits per counter (1..32)
//   CHANNELS     number of counters (1..16)
//   CH_BITS      channel index width, 2**CH_BITS >= CHANNELS
//   RESET_VALUE  value every counter takes while reset_n is low
//
// Ports:
//   clock       in   rising-edge clock for all state
//   reset_n     in   asynchronous active-low reset
//   inc         in   [CHANNELS]  per-channel increment request
//   dec         in   [CHANNELS]  per-channel decrement request
//   sat_mode    in   [CHANNELS]  1 = saturate at bounds, 0 = wrap
//   load_en     in   load strobe
//   load_chan   in   [CH_BITS]   channel to load (out-of-range: ignored)
//   load_value  in   [WIDTH]     value to load
//   clr_flags   in   clear all sticky overflow flags
//   rd_chan     in   [CH_BITS]   read-port channel select
//   counts      out  [CHANNELS*WIDTH]  channel i at [i*WIDTH +: WIDTH]
//   rd_value    out  [WIDTH]     combinational read of rd_chan, 0 if out of range
//   wrap_pulse  out  [CHANNELS]  one-cycle pulse after a wrap
//   sat_hit     out  [CHANNELS]  one-cycle pulse after a clipped inc/dec
//   ovf_sticky  out  [CHANNELS]  set by wrap/sat events, cleared by clr_flags
//
// Strobe semantics: inc, dec, load_en and clr_flags are plain per-cycle
// requests with no backpressure. Every request that is present at a rising
// edge is acted on at that edge, and its effect is visible right after it.
// -----------------------------------------------------------------------------
module counter_bank #(
    parameter int unsigned            WIDTH       = 8,
    parameter int unsigned            CHANNELS    = 4,
    parameter int unsigned            CH_BITS     = 2,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       inc,
    input  logic [CHANNELS-1:0]       dec,
    input  logic [CHANNELS-1:0]       sat_mode,
    input  logic                      load_en,
    input  logic [CH_BITS-1:0]        load_chan,
    input  logic [WIDTH-1:0]          load_value,
    input  logic                      clr_flags,
    input  logic [CH_BITS-1:0]        rd_chan,
    output logic [CHANNELS*WIDTH-1:0] counts,
    output logic [WIDTH-1:0]          rd_value,
    output logic [CHANNELS-1:0]       wrap_pulse,
    output logic [CHANNELS-1:0]       sat_hit,
    output logic [CHANNELS-1:0]       ovf_sticky
);

    localparam logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VALUE = '0;

    // Registered state
    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [CHANNELS-1:0] wrap_q;
    logic [CHANNELS-1:0] sat_q;
    logic [CHANNELS-1:0] ovf_q;

    // Next-state values
    logic [WIDTH-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] wrap_d;
    logic [CHANNELS-1:0] sat_d;
    logic [CHANNELS-1:0] ovf_d;
    logic [CHANNELS-1:0] load_hit;

    // Load decode. A load_chan value at or above CHANNELS matches no channel,
    // so an out-of-range load has no effect at all.
    always_comb begin
        load_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (load_en && (load_chan == CH_BITS'(i))) begin
                load_hit[i] = 1'b1;
            end
        end
    end

    // Per-channel update. The priority is load, then inc+dec (hold), then a
    // single inc or dec. Events happen only when a lone inc or dec hits a
    // bound.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]  = cnt_q[i];
            wrap_d[i] = 1'b0;
            sat_d[i]  = 1'b0;

            if (load_hit[i]) begin
                cnt_d[i] = load_value;
            end else if (inc[i] && !dec[i]) begin
                if (cnt_q[i] != MAX_VALUE) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end else if (sat_mode[i]) begin
                    sat_d[i] = 1'b1;
                end else begin
                    cnt_d[i]  = MIN_VALUE;
                    wrap_d[i] = 1'b1;
                end
            end else if (dec[i] && !inc[i]) begin
                if (cnt_q[i] != MIN_VALUE) begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end else if (sat_mode[i]) begin
                    sat_d[i] = 1'b1;
                end else begin
                    cnt_d[i]  = MAX_VALUE;
                    wrap_d[i] = 1'b1;
                end
            end
        end
    end

    // If a new event coincides with clr_flags, the set takes priority.
    always_comb begin
        ovf_d = (wrap_d | sat_d) | (ovf_q & ~{CHANNELS{clr_flags}});
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= RESET_VALUE;
            end
            wrap_q <= '0;
            sat_q  <= '0;
            ovf_q  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
            ovf_q  <= ovf_d;
        end
    end

    // Flat register view
    for (genvar g = 0; g < CHANNELS; g++) begin : g_counts
        assign counts[g*WIDTH +: WIDTH] = cnt_q[g];
    end

    // Zero-latency read port. An out-of-range select matches no channel and
    // returns 0.
    always_comb begin
        rd_value = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_chan == CH_BITS'(i)) begin
                rd_value = cnt_q[i];
            end
        end
    end

    assign wrap_pulse = wrap_q;
    assign sat_hit    = sat_q;
    assign ovf_sticky = ovf_q;

endmodule
